// File: rtl/voice_bank_mux_pkg.sv
// Shared encodings for the time-multiplexed voice engine: waveform codes,
// envelope states and top-level sequencer states.
package voice_bank_mux_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_OFF   = 2'd3
    } wave_e;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_DONE = 2'd2
    } top_state_e;

    // Amplitude is the top AMP_BITS of the envelope level.
    localparam int AMP_BITS = 8;

endpackage

// File: rtl/voice_bank_mux_envelope_step.sv
// Combinational ADSR step for one voice: next state and next level from the
// stored state/level, the sampled gate and the shared rates.
module envelope_step
    import voice_bank_mux_pkg::*;
#(
    parameter int ENV_BITS = 16
) (
    input  env_state_e           i_state,
    input  logic [ENV_BITS-1:0]  i_level,
    input  logic                 i_gate,
    input  logic                 i_gate_prev,
    input  logic [ENV_BITS-1:0]  i_attack_inc,
    input  logic [ENV_BITS-1:0]  i_decay_inc,
    input  logic [ENV_BITS-1:0]  i_release_inc,
    input  logic [AMP_BITS-1:0]  i_sustain_level,
    output env_state_e           o_state,
    output logic [ENV_BITS-1:0]  o_level
);

    localparam int SUS_PAD = ENV_BITS - AMP_BITS;

    logic [ENV_BITS-1:0] w_sus;
    logic [ENV_BITS:0]   w_att_sum;
    logic [ENV_BITS:0]   w_dec_diff;
    logic [ENV_BITS:0]   w_rel_diff;
    env_state_e          w_eff;

    assign w_sus      = {i_sustain_level, {SUS_PAD{1'b0}}};
    assign w_att_sum  = {1'b0, i_level} + {1'b0, i_attack_inc};
    assign w_dec_diff = {1'b0, i_level} - {1'b0, i_decay_inc};
    assign w_rel_diff = {1'b0, i_level} - {1'b0, i_release_inc};

    // Gate edges redirect the state first; the step of the new state applies
    // in the same evaluation, starting from the retained level.
    always_comb begin
        w_eff = i_state;
        if (i_gate && !i_gate_prev) begin
            w_eff = ENV_ATTACK;
        end else if (!i_gate && (i_state == ENV_ATTACK || i_state == ENV_DECAY ||
                                 i_state == ENV_SUSTAIN)) begin
            w_eff = ENV_RELEASE;
        end
    end

    always_comb begin
        o_state = w_eff;
        o_level = i_level;
        case (w_eff)
            ENV_ATTACK: begin
                if (w_att_sum[ENV_BITS] || (&w_att_sum[ENV_BITS-1:0])) begin
                    o_level = '1;
                    o_state = ENV_DECAY;
                end else begin
                    o_level = w_att_sum[ENV_BITS-1:0];
                end
            end
            ENV_DECAY: begin
                if (w_dec_diff[ENV_BITS] || (w_dec_diff[ENV_BITS-1:0] <= w_sus)) begin
                    o_level = w_sus;
                    o_state = ENV_SUSTAIN;
                end else begin
                    o_level = w_dec_diff[ENV_BITS-1:0];
                end
            end
            ENV_SUSTAIN: o_level = w_sus;
            ENV_RELEASE: begin
                if (w_rel_diff[ENV_BITS] || (w_rel_diff[ENV_BITS-1:0] == '0)) begin
                    o_level = '0;
                    o_state = ENV_IDLE;
                end else begin
                    o_level = w_rel_diff[ENV_BITS-1:0];
                end
            end
            default: o_level = i_level;
        endcase
    end

endmodule

// File: rtl/voice_bank_mux.sv
// Polyphonic voice engine: NUM_VOICES voices share one oscillator/envelope/
// scaling datapath, one voice per cycle after sample_tick. Ring modulation
// of the triangle is enabled with TINY_SYNTH_RINGMOD_EN.
module voice_bank_mux
    import voice_bank_mux_pkg::*;
#(
    parameter int NUM_VOICES       = 4,
    parameter int OUTPUT_BITS      = 12,
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int ENV_BITS         = 16
) (
    input  logic                           main_clk,
    input  logic                           rst_n,
    input  logic                           sample_tick,
    input  logic                           freq_we,
    input  logic [$clog2(NUM_VOICES)-1:0]  freq_voice,
    input  logic [FREQ_BITS-1:0]           freq_data,
    input  logic [2*NUM_VOICES-1:0]        waveform,
    input  logic [PULSEWIDTH_BITS-1:0]     pulse_width,
    input  logic [NUM_VOICES-1:0]          gate,
`ifdef TINY_SYNTH_RINGMOD_EN
    input  logic [NUM_VOICES-1:0]          en_ringmod,
`endif
    input  logic [ENV_BITS-1:0]            attack_inc,
    input  logic [ENV_BITS-1:0]            decay_inc,
    input  logic [ENV_BITS-1:0]            release_inc,
    input  logic [AMP_BITS-1:0]            sustain_level,
    output logic signed [OUTPUT_BITS-1:0]  dout,
    output logic                           dout_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [NUM_VOICES-1:0]          is_idle,
    output logic [1:0]                     dbg_state
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int OB    = OUTPUT_BITS;
    localparam int ACC   = ACCUMULATOR_BITS;
    localparam int MW    = OB + VW;
    localparam int PRODW = OB + AMP_BITS + 1;

    localparam logic signed [OB-1:0] S_POS   = {1'b0, {(OB-1){1'b1}}};
    localparam logic signed [OB-1:0] S_NEG   = {1'b1, {(OB-2){1'b0}}, 1'b1};
    localparam logic signed [MW-1:0] MIX_MAX = {{(VW+1){1'b0}}, {(OB-1){1'b1}}};
    localparam logic signed [MW-1:0] MIX_MIN = ~MIX_MAX;

    top_state_e            r_state;
    top_state_e            w_state_next;
    logic [VW-1:0]         r_voice;
    logic                  w_last;
    logic                  w_busy;

    logic [ACC-1:0]        r_phase [NUM_VOICES];
    logic [FREQ_BITS-1:0]  r_freq  [NUM_VOICES];
    logic [ENV_BITS-1:0]   r_level [NUM_VOICES];
    env_state_e            r_env   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate_prev;

    logic signed [MW-1:0]  r_mix;
    logic signed [OB-1:0]  r_dout;
    logic                  r_dout_valid;
    logic                  r_overrun;

    logic [ACC-1:0]        w_phase;
    logic [ENV_BITS-1:0]   w_level;
    logic [AMP_BITS-1:0]   w_amp;
    wave_e                 w_wave;
    logic [OB-1:0]         w_tri_fold;
    logic signed [OB-1:0]  w_tri;
    logic signed [OB-1:0]  w_sample;
    logic signed [PRODW-1:0] w_prod;
    logic signed [PRODW-1:0] w_shift;
    logic signed [OB-1:0]  w_scaled;
    logic signed [MW-1:0]  w_mix_next;
    logic signed [OB-1:0]  w_sat;
    env_state_e            w_env_next;
    logic [ENV_BITS-1:0]   w_level_next;
    logic                  w_unused;

    // ---------------- top sequencer ----------------
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) r_state <= TOP_IDLE;
        else        r_state <= w_state_next;
    end

    assign w_last = (r_voice == VW'(NUM_VOICES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TOP_IDLE: if (sample_tick) w_state_next = TOP_RUN;
            TOP_RUN:  if (w_last)      w_state_next = TOP_DONE;
            TOP_DONE:                  w_state_next = TOP_IDLE;
            default:                   w_state_next = TOP_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != TOP_IDLE);
        busy      = w_busy;
        dbg_state = r_state;
    end

    // ---------------- shared voice datapath ----------------
    assign w_phase = r_phase[r_voice];
    assign w_level = r_level[r_voice];
    assign w_amp   = w_level[ENV_BITS-1 -: AMP_BITS];
    assign w_wave  = wave_e'(waveform[{r_voice, 1'b0} +: 2]);

`ifdef TINY_SYNTH_RINGMOD_EN
    logic [VW-1:0] w_src_voice;
    assign w_src_voice = (r_voice == '0) ? VW'(NUM_VOICES - 1) : (r_voice - VW'(1));
`endif

    always_comb begin
        w_tri_fold = w_phase[ACC-2 -: OB] ^ {OB{w_phase[ACC-1]}};
        w_tri      = {~w_tri_fold[OB-1], w_tri_fold[OB-2:0]};
`ifdef TINY_SYNTH_RINGMOD_EN
        // Source phase is read as stored: already advanced for earlier voices.
        if (en_ringmod[r_voice] && r_phase[w_src_voice][ACC-1]) w_tri = -w_tri;
`endif
        case (w_wave)
            WAVE_SAW:   w_sample = {~w_phase[ACC-1], w_phase[ACC-2 -: OB-1]};
            WAVE_PULSE: w_sample = (w_phase[ACC-1 -: PULSEWIDTH_BITS] >= pulse_width) ? S_POS : S_NEG;
            WAVE_TRI:   w_sample = w_tri;
            default:    w_sample = '0;
        endcase
    end

    assign w_prod     = PRODW'(w_sample) * $signed(PRODW'(w_amp));
    assign w_shift    = w_prod >>> AMP_BITS;
    assign w_scaled   = w_shift[OB-1:0];
    assign w_mix_next = r_mix + MW'(w_scaled);
    assign w_unused   = ^{w_shift[PRODW-1:OB]};

    always_comb begin
        if (w_mix_next > MIX_MAX)      w_sat = S_POS;
        else if (w_mix_next < MIX_MIN) w_sat = {1'b1, {(OB-1){1'b0}}};
        else                           w_sat = w_mix_next[OB-1:0];
    end

    envelope_step #(
        .ENV_BITS (ENV_BITS)
    ) u_env (
        .i_state         (r_env[r_voice]),
        .i_level         (w_level),
        .i_gate          (gate[r_voice]),
        .i_gate_prev     (r_gate_prev[r_voice]),
        .i_attack_inc    (attack_inc),
        .i_decay_inc     (decay_inc),
        .i_release_inc   (release_inc),
        .i_sustain_level (sustain_level),
        .o_state         (w_env_next),
        .o_level         (w_level_next)
    );

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_freq[i]  <= '0;
                r_level[i] <= '0;
                r_env[i]   <= ENV_IDLE;
            end
            r_gate_prev  <= '0;
            r_voice      <= '0;
            r_mix        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_overrun    <= sample_tick && w_busy;
            if (freq_we) r_freq[freq_voice] <= freq_data;
            if (r_state == TOP_IDLE && sample_tick) begin
                r_mix   <= '0;
                r_voice <= '0;
            end
            if (r_state == TOP_RUN) begin
                r_phase[r_voice]     <= w_phase + ACC'(r_freq[r_voice]);
                r_level[r_voice]     <= w_level_next;
                r_env[r_voice]       <= w_env_next;
                r_gate_prev[r_voice] <= gate[r_voice];
                r_mix                <= w_mix_next;
                r_voice              <= r_voice + VW'(1);
                // Output lands as the sequencer enters DONE.
                if (w_last) begin
                    r_dout       <= w_sat;
                    r_dout_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) is_idle[i] = (r_env[i] == ENV_IDLE);
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;

endmodule
